// File: rtl/pipe_stage_elastic_pkg.sv
// Shared defaults and sizing helpers for the elastic pipeline stage.
package pipe_stage_elastic_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 2;
    localparam int DEF_CNT_W  = 16;

    // A single-entry stage still needs a 1-bit pointer so the vectors stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_fifo_mem.sv
// DEPTH x DATA_W register array for the elastic stage: one write port, asynchronous read.
module pipe_fifo_mem
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    // Payload storage carries no reset; validity is tracked by the stage's count.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: skid FIFO with valid/ready handshake, synchronous flush,
// zero-payload bubbles and a saturating bubble counter.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int ZERO_ON_BUBBLE = 1,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [OCC_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;

    // A full stage still accepts when the head leaves in the same cycle.
    assign in_ready  = ~flush & ((count < FULL_CNT) | out_ready);
    assign out_valid = ~flush & (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = count;

    generate
        if (ZERO_ON_BUBBLE != 0) begin : g_zero_bubble
            assign out_data = out_valid ? head : '0;
        end else begin : g_raw_head
            assign out_data = head;
        end
    endgenerate

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    pipe_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Flush cycles present out_valid=0, so they count as bubbles when downstream is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (out_ready & ~out_valid & (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomized checks of pipe_stage_elastic across DEPTH=1/2/3 and a narrow
// bubble counter, against a queue-based reference model.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a: DEPTH=1
    logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [31:0] a_in_data = 0, a_out_data;
    logic [0:0]  a_occ;
    logic [15:0] a_bub;
    // b: DEPTH=2
    logic b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [31:0] b_in_data = 0, b_out_data;
    logic [1:0]  b_occ;
    logic [15:0] b_bub;
    // c: DEPTH=3
    logic c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [31:0] c_in_data = 0, c_out_data;
    logic [1:0]  c_occ;
    logic [15:0] c_bub;
    // d: DEPTH=2, CNT_W=3
    logic d_flush = 0, d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0;
    logic [31:0] d_in_data = 0, d_out_data;
    logic [1:0]  d_occ;
    logic [2:0]  d_bub;

    pipe_stage_elastic #(.DATA_W(32), .DEPTH(1), .ZERO_ON_BUBBLE(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .occupancy(a_occ), .bubble_cnt(a_bub));

    pipe_stage_elastic #(.DATA_W(32), .DEPTH(2), .ZERO_ON_BUBBLE(1), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .occupancy(b_occ), .bubble_cnt(b_bub));

    pipe_stage_elastic #(.DATA_W(32), .DEPTH(3), .ZERO_ON_BUBBLE(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .occupancy(c_occ), .bubble_cnt(c_bub));

    pipe_stage_elastic #(.DATA_W(32), .DEPTH(2), .ZERO_ON_BUBBLE(1), .CNT_W(3)) u_d (
        .clk(clk), .rst(rst), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .occupancy(d_occ), .bubble_cnt(d_bub));

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic        exp_ready, exp_valid;
    logic [31:0] exp_data;
    int          exp_bubble;

    initial begin
        // Reset state
        #3;
        chk_bit ("rst_out_valid", b_out_valid, 1'b0);
        chk_word("rst_occ",       32'(b_occ), 32'd0);
        chk_word("rst_bubble",    32'(b_bub), 32'd0);
        chk_word("rst_out_data",  b_out_data, 32'd0);
        step();
        rst = 1'b1;

        // DEPTH=1 streaming
        a_out_ready = 1; a_in_valid = 1; a_in_data = 32'h11; #1;
        chk_bit ("s1_in_ready0", a_in_ready, 1'b1);
        chk_bit ("s1_valid0",    a_out_valid, 1'b0);
        step(); a_in_data = 32'h22; #1;
        chk_word("s1_out11", a_out_data, 32'h11);
        chk_bit ("s1_in_ready1", a_in_ready, 1'b1);
        step(); a_in_data = 32'h33; #1;
        chk_word("s1_out22", a_out_data, 32'h22);
        chk_bit ("s1_in_ready2", a_in_ready, 1'b1);
        step(); a_in_valid = 0; #1;
        chk_word("s1_out33", a_out_data, 32'h33);
        chk_bit ("s1_valid33", a_out_valid, 1'b1);
        step(); #1;
        chk_bit ("s1_empty_valid", a_out_valid, 1'b0);
        chk_word("s1_empty_data",  a_out_data, 32'd0);
        a_out_ready = 0;

        // DEPTH=2 back-pressure
        b_out_ready = 0; b_in_valid = 1; b_in_data = 32'hA; #1;
        chk_bit ("bp_ready0", b_in_ready, 1'b1);
        step(); b_in_data = 32'hB; #1;
        chk_word("bp_occ1", 32'(b_occ), 32'd1);
        chk_word("bp_headA", b_out_data, 32'hA);
        step(); b_in_data = 32'hC; #1;
        chk_word("bp_occ2", 32'(b_occ), 32'd2);
        chk_bit ("bp_full_ready", b_in_ready, 1'b0);
        step(); #1;
        chk_word("bp_held_occ", 32'(b_occ), 32'd2);
        chk_word("bp_held_head", b_out_data, 32'hA);
        b_out_ready = 1; #1;
        chk_bit ("bp_skid_ready", b_in_ready, 1'b1);
        step(); b_in_valid = 0; #1;
        chk_word("bp_outB", b_out_data, 32'hB);
        chk_word("bp_occ_B", 32'(b_occ), 32'd2);
        step(); #1;
        chk_word("bp_outC", b_out_data, 32'hC);
        chk_word("bp_occ_C", 32'(b_occ), 32'd1);
        step(); #1;
        chk_bit ("bp_drained", b_out_valid, 1'b0);
        chk_word("bp_occ0", 32'(b_occ), 32'd0);

        // Flush with two entries and an incoming payload
        b_out_ready = 0; b_in_valid = 1; b_in_data = 32'h1;
        step(); b_in_data = 32'h2;
        step(); #1;
        chk_word("fl_pre_occ", 32'(b_occ), 32'd2);
        b_flush = 1; b_in_data = 32'hD; #1;
        chk_bit ("fl_in_ready", b_in_ready, 1'b0);
        chk_bit ("fl_out_valid", b_out_valid, 1'b0);
        chk_word("fl_out_data", b_out_data, 32'd0);
        step(); b_flush = 0; b_in_valid = 0; #1;
        chk_word("fl_occ", 32'(b_occ), 32'd0);
        chk_bit ("fl_valid", b_out_valid, 1'b0);
        chk_word("fl_data", b_out_data, 32'd0);
        b_in_valid = 1; b_in_data = 32'hE;
        step(); b_in_valid = 0; #1;
        chk_word("fl_after_data", b_out_data, 32'hE);
        chk_word("fl_after_occ", 32'(b_occ), 32'd1);
        b_out_ready = 1;
        step();
        b_out_ready = 0;

        // Asynchronous reset mid-stream
        b_in_valid = 1; b_in_data = 32'h5;
        step(); b_in_data = 32'h6;
        step(); b_in_valid = 0; #1;
        chk_word("ar_pre_occ", 32'(b_occ), 32'd2);
        #2 rst = 0;
        #1;
        chk_bit ("ar_valid", b_out_valid, 1'b0);
        chk_word("ar_occ", 32'(b_occ), 32'd0);
        chk_word("ar_bubble", 32'(b_bub), 32'd0);
        step(); rst = 1;
        b_in_valid = 1; b_in_data = 32'h77;
        step(); b_in_valid = 0; #1;
        chk_word("ar_first_data", b_out_data, 32'h77);
        chk_word("ar_first_occ", 32'(b_occ), 32'd1);

        // Bubble counting and saturation
        c_out_ready = 1; d_out_ready = 1;
        repeat (5) step();
        #1;
        chk_word("bub_c5", 32'(c_bub), 32'd5);
        chk_word("bub_d5", 32'(d_bub), 32'd5);
        repeat (5) step();
        #1;
        chk_word("bub_d_sat", 32'(d_bub), 32'd7);
        chk_word("bub_c10", 32'(c_bub), 32'd10);
        c_flush = 1;
        step(); c_flush = 0; #1;
        chk_word("bub_c_flush", 32'(c_bub), 32'd11);
        d_out_ready = 0;

        // Random traffic on DEPTH=3 against a queue model
        exp_bubble = 11;
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            c_flush     = ($urandom_range(0, 39) == 0);
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_in_data   = $urandom;
            c_out_ready = ($urandom_range(0, 2) != 0);
            exp_ready = !c_flush && (q.size() < 3 || c_out_ready);
            exp_valid = !c_flush && (q.size() != 0);
            exp_data  = exp_valid ? q[0] : 32'd0;
            #1;
            chk_bit ("rnd_in_ready", c_in_ready, exp_ready);
            chk_bit ("rnd_out_valid", c_out_valid, exp_valid);
            chk_word("rnd_out_data", c_out_data, exp_data);
            chk_word("rnd_occ", 32'(c_occ), 32'(q.size()));
            if (c_out_ready && !exp_valid) exp_bubble++;
            if (c_flush) begin
                q.delete();
            end else begin
                if (exp_valid && c_out_ready) void'(q.pop_front());
                if (c_in_valid && exp_ready) q.push_back(c_in_data);
            end
            step();
        end
        #1;
        chk_word("rnd_bubble", 32'(c_bub), 32'(exp_bubble));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
